calc_sequencer: RTL and testbench

- Controller for the calculator datapath. Accepts one operation request (add, subtract, Euclidean divide, modulo) on a start/busy/done handshake.
- Sequences a multi-cycle restoring divider that produces one quotient bit per cycle, then a multi-cycle binary-to-BCD conversion.
- Produces the 16-bit digit word consumed by the 4-digit display block: 4 nibbles, nibble 0 is the rightmost digit, codes above 9 render as a dash.

---
 rtl/calc_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator datapath controller: add/sub/Euclidean div/mod, restoring divider, BCD display word
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start, op, a, b request strobe (taken in IDLE only), opcode 0=ADD 1=SUB 2=DIV 3=MOD, signed operands
//   busy, done      operation in flight, one-cycle completion pulse
//   err             last operation was a divide/modulo by zero
//   result          signed binary result of the last operation
//   digits          4-nibble display word, nibble 0 rightmost; 0xA renders as minus, 0xE/0xF as dashes
module calc_sequencer #(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [BITS-1:0] result,
    output logic [15:0]     digits
);

    localparam int CW = $clog2(BITS);
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MOD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_PREP, S_ITER, S_FIX, S_CONV, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]      op_r;
    logic [BITS-1:0] a_r, b_r;
    logic [BITS-1:0] ua, ub;     // |a| shifts out MSB first; |b| is the divisor
    logic [BITS-1:0] rem, quo;
    logic [BITS-1:0] calc;       // signed result awaiting conversion
    logic [BITS-1:0] bin;        // |calc| being shifted into the BCD register
    logic [19:0]     bcd;
    logic [CW-1:0]   cnt;

    function automatic logic [BITS-1:0] abs_val(input logic [BITS-1:0] v);
        return v[BITS-1] ? (~v + 1'b1) : v;
    endfunction

    // Restoring divide step
    logic [BITS:0]   rem_sh;
    logic            ge;
    logic [BITS-1:0] rem_new;

    // Euclidean fix-up
    logic [BITS-1:0] q0, r0, q1, fix_val, sum;

    // Double-dabble step and display formatting
    logic [19:0]     bcd_adj, bcd_nxt;
    logic [BITS-1:0] bin_nxt;
    logic            bcd_carry;
    logic [15:0]     fmt;

    always_comb begin
        rem_sh  = {rem, ua[BITS-1]};
        ge      = rem_sh >= {1'b0, ub};
        rem_new = ge ? BITS'(rem_sh - {1'b0, ub}) : rem_sh[BITS-1:0];

        sum = (op_r == OP_SUB) ? (a_r - b_r) : (a_r + b_r);

        // a < 0 pulls the quotient down by one whenever there is a remainder,
        // so the remainder can be reflected into [0, |b|).
        if (!a_r[BITS-1]) begin
            q0 = quo;
            r0 = rem;
        end else if (rem == '0) begin
            q0 = ~quo + 1'b1;
            r0 = '0;
        end else begin
            q0 = ~quo;
            r0 = ub - rem;
        end
        q1      = b_r[BITS-1] ? (~q0 + 1'b1) : q0;
        fix_val = (op_r == OP_MOD) ? r0 : q1;

        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        {bcd_carry, bcd_nxt, bin_nxt} = {bcd_adj, bin, 1'b0};

        // Formatting uses the post-shift value so it is valid on the last CONV cycle.
        if (!calc[BITS-1] && !bcd_carry && bcd_nxt[19:16] == 4'd0)
            fmt = bcd_nxt[15:0];
        else if (calc[BITS-1] && !bcd_carry && bcd_nxt[19:12] == 8'd0)
            fmt = {4'hA, bcd_nxt[11:0]};
        else
            fmt = 16'hFFFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = op[1] ? S_PREP : S_CALC;
            end
            S_CALC: state_nxt = S_CONV;
            S_PREP: state_nxt = (b_r == '0) ? S_DONE : S_ITER;
            S_ITER: if (cnt == '0) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_CONV;
            S_CONV: if (cnt == '0) state_nxt = S_DONE;
            S_DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output registers are loaded on the edge entering DONE, so they are valid while done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            ua     <= '0;
            ub     <= '0;
            rem    <= '0;
            quo    <= '0;
            calc   <= '0;
            bin    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            result <= '0;
            digits <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    op_r <= op;
                    a_r  <= a;
                    b_r  <= b;
                    err  <= 1'b0;
                end
                S_CALC: begin
                    calc <= sum;
                    bin  <= abs_val(sum);
                    bcd  <= '0;
                    cnt  <= CW'(BITS - 1);
                end
                S_PREP: begin
                    if (b_r == '0) begin
                        err    <= 1'b1;
                        result <= '0;
                        digits <= 16'hEEEE;
                    end else begin
                        ua  <= abs_val(a_r);
                        ub  <= abs_val(b_r);
                        rem <= '0;
                        quo <= '0;
                        cnt <= CW'(BITS - 1);
                    end
                end
                S_ITER: begin
                    rem <= rem_new;
                    quo <= {quo[BITS-2:0], ge};
                    ua  <= {ua[BITS-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    calc <= fix_val;
                    bin  <= abs_val(fix_val);
                    bcd  <= '0;
                    cnt  <= CW'(BITS - 1);
                end
                S_CONV: begin
                    bcd <= bcd_nxt;
                    bin <= bin_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= calc;
                        digits <= fmt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done, err;
    logic [15:0] result, digits;

    int checks = 0;
    int errors = 0;

    calc_sequencer #(.BITS(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .digits (digits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble the inputs after accept, pulse start while busy,
    // then measure latency (edges from accept to the edge that samples done) and check outputs.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] av,
                          input logic [15:0] bv, input int lat, input logic [15:0] er,
                          input logic [15:0] ed, input logic ee);
        int  m;
        bit  seen;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 2'd1; a = 16'h1111; b = 16'h0001;
        m = 0;
        seen = 1'b0;
        while (!seen && m < 100) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (m == 3) start = 1'b1;
                if (m == 4) start = 1'b0;
                @(negedge clk);
                m++;
            end
        end
        start = 1'b0;
        check({tag, " latency"}, seen ? m + 1 : -1, lat);
        check({tag, " result"}, {16'h0, result}, {16'h0, er});
        check({tag, " digits"}, {16'h0, digits}, {16'h0, ed});
        check({tag, " err"}, {31'h0, err}, {31'h0, ee});
        @(negedge clk);
        check({tag, " done pulse"}, {31'h0, done}, 32'h0);
        check({tag, " idle"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; op = 2'd0; a = 16'h0; b = 16'h0;
        repeat (2) @(negedge clk);
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst done", {31'h0, done}, 32'h0);
        check("rst err", {31'h0, err}, 32'h0);
        check("rst result", {16'h0, result}, 32'h0);
        check("rst digits", {16'h0, digits}, 32'h0);
        rst_n = 1'b1;

        run_op("add",      2'd0, 16'd1234, 16'd4321, 18, 16'd5555, 16'h5555, 1'b0);
        run_op("div7/-2",  2'd2, 16'd7,    16'hFFFE, 35, 16'hFFFD, 16'hA003, 1'b0);
        run_op("mod-7/2",  2'd3, 16'hFFF9, 16'd2,    35, 16'd1,    16'h0001, 1'b0);
        run_op("div-7/2",  2'd2, 16'hFFF9, 16'd2,    35, 16'hFFFC, 16'hA004, 1'b0);
        run_op("divmin/1", 2'd2, 16'h8000, 16'd1,    35, 16'h8000, 16'hFFFF, 1'b0);
        run_op("modmin/7", 2'd3, 16'h8000, 16'd7,    35, 16'd6,    16'h0006, 1'b0);
        run_op("div/0",    2'd2, 16'd100,  16'd0,    2,  16'd0,    16'hEEEE, 1'b1);
        run_op("add1+1",   2'd0, 16'd1,    16'd1,    18, 16'd2,    16'h0002, 1'b0);
        run_op("sub-999",  2'd1, 16'd0,    16'd999,  18, 16'hFC19, 16'hA999, 1'b0);
        run_op("sub-1000", 2'd1, 16'd0,    16'd1000, 18, 16'hFC18, 16'hFFFF, 1'b0);
        run_op("addwrap",  2'd0, 16'd32767, 16'd1,   18, 16'h8000, 16'hFFFF, 1'b0);
        run_op("div9999/3", 2'd2, 16'd9999, 16'd3,   35, 16'd3333, 16'h3333, 1'b0);

        // Abandon a divide mid-flight with reset.
        @(negedge clk);
        start = 1'b1; op = 2'd2; a = 16'd9999; b = 16'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-rst busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst busy", {31'h0, busy}, 32'h0);
        check("arst done", {31'h0, done}, 32'h0);
        check("arst err", {31'h0, err}, 32'h0);
        check("arst result", {16'h0, result}, 32'h0);
        check("arst digits", {16'h0, digits}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no done after rst", dones, 0);
        check("idle after rst", {31'h0, busy}, 32'h0);

        run_op("add5+4",   2'd0, 16'd5,    16'd4,    18, 16'd9,    16'h0009, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
